// File: rtl/wb_register_file.sv
// Writeback stage and general-purpose register file at the consuming end of
// the MEM/WB pipeline register. The writeback source is selected per MemtoReg
// and committed on the clock edge. Two combinational read ports serve ID with
// write-through bypass. A registered copy of the last commit feeds late
// forwarding, and a counter records the number of commits since reset.
module wb_register_file #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      In_RegWrite,
    input  logic [1:0]                In_MemtoReg,
    input  logic [DATA_W-1:0]         In_RAM_Data,
    input  logic [DATA_W-1:0]         In_Immediate_Data,
    input  logic [DATA_W-1:0]         In_PC,
    input  logic [$clog2(NREGS)-1:0]  In_Rd,
    input  logic [$clog2(NREGS)-1:0]  In_Rs_Addr,
    input  logic [$clog2(NREGS)-1:0]  In_Rt_Addr,
    output logic [DATA_W-1:0]         Out_Rs_Data,
    output logic [DATA_W-1:0]         Out_Rt_Data,
    output logic [DATA_W-1:0]         Out_WB_Data,
    output logic [$clog2(NREGS)-1:0]  Out_Last_Rd,
    output logic [DATA_W-1:0]         Out_Last_Data,
    output logic                      Out_Last_Valid,
    output logic [CNT_W-1:0]          Out_Commit_Count
);

    localparam int ADDR_W = $clog2(NREGS);

    // Writeback source encoding carried by MemtoReg; the last code is reserved.
    typedef enum logic [1:0] {
        SRC_IMM  = 2'b00,
        SRC_RAM  = 2'b01,
        SRC_PC   = 2'b10,
        SRC_RSVD = 2'b11
    } wb_src_e;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [ADDR_W-1:0] last_rd_q;
    logic [DATA_W-1:0] last_data_q;
    logic              last_valid_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic [DATA_W-1:0] wb_data;
    logic              commit;

    // Select the writeback value; the reserved code yields zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wb_data = '0;
        unique case (wb_src_e'(In_MemtoReg))
            SRC_IMM:  wb_data = In_Immediate_Data;
            SRC_RAM:  wb_data = In_RAM_Data;
            SRC_PC:   wb_data = In_PC;
            SRC_RSVD: wb_data = '0;
            default:  wb_data = '0;
        endcase
    end

    // A commit needs a write enable, a non-zero target and a legal source.
    always_comb begin
        commit = In_RegWrite && (In_Rd != '0) &&
                 (wb_src_e'(In_MemtoReg) != SRC_RSVD);
    end

    // Read port A: r0 is zero, a same-cycle commit to the address is bypassed.
    always_comb begin
        Out_Rs_Data = regs_q[In_Rs_Addr];
        if (In_Rs_Addr == '0) begin
            Out_Rs_Data = '0;
        end else if (commit && (In_Rs_Addr == In_Rd)) begin
            Out_Rs_Data = wb_data;
        end
    end

    // Read port B: same rules as port A, bypassed independently.
    always_comb begin
        Out_Rt_Data = regs_q[In_Rt_Addr];
        if (In_Rt_Addr == '0) begin
            Out_Rt_Data = '0;
        end else if (commit && (In_Rt_Addr == In_Rd)) begin
            Out_Rt_Data = wb_data;
        end
    end

    // Next commit count; wraps naturally at 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (commit) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Commit into the array and track the last commit and the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset explicitly because reads after reset
            // must return zero for every address; this costs a reset net on
            // each storage bit, so it cannot map onto a plain RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            last_rd_q    <= '0;
            last_data_q  <= '0;
            last_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (commit) begin
                regs_q[In_Rd] <= wb_data;
                last_rd_q     <= In_Rd;
                last_data_q   <= wb_data;
            end
            last_valid_q <= commit;
            count_q      <= count_d;
        end
    end

    assign Out_WB_Data      = wb_data;
    assign Out_Last_Rd      = last_rd_q;
    assign Out_Last_Data    = last_data_q;
    assign Out_Last_Valid   = last_valid_q;
    assign Out_Commit_Count = count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file. The counter is built 4 bits wide so
// that wrap-around is reachable in a handful of commits.
module tb_wb_register_file;

    localparam int CNT_W = 4;

    logic              clk;
    logic              rst;
    logic              In_RegWrite;
    logic [1:0]        In_MemtoReg;
    logic [31:0]       In_RAM_Data;
    logic [31:0]       In_Immediate_Data;
    logic [31:0]       In_PC;
    logic [4:0]        In_Rd;
    logic [4:0]        In_Rs_Addr;
    logic [4:0]        In_Rt_Addr;
    logic [31:0]       Out_Rs_Data;
    logic [31:0]       Out_Rt_Data;
    logic [31:0]       Out_WB_Data;
    logic [4:0]        Out_Last_Rd;
    logic [31:0]       Out_Last_Data;
    logic              Out_Last_Valid;
    logic [CNT_W-1:0]  Out_Commit_Count;

    int total_checks;
    int passed_checks;

    wb_register_file #(
        .NREGS  (32),
        .DATA_W (32),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .In_RegWrite       (In_RegWrite),
        .In_MemtoReg       (In_MemtoReg),
        .In_RAM_Data       (In_RAM_Data),
        .In_Immediate_Data (In_Immediate_Data),
        .In_PC             (In_PC),
        .In_Rd             (In_Rd),
        .In_Rs_Addr        (In_Rs_Addr),
        .In_Rt_Addr        (In_Rt_Addr),
        .Out_Rs_Data       (Out_Rs_Data),
        .Out_Rt_Data       (Out_Rt_Data),
        .Out_WB_Data       (Out_WB_Data),
        .Out_Last_Rd       (Out_Last_Rd),
        .Out_Last_Data     (Out_Last_Data),
        .Out_Last_Valid    (Out_Last_Valid),
        .Out_Commit_Count  (Out_Commit_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] mtr, input logic [31:0] ram,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        In_RegWrite       = rw;
        In_MemtoReg       = mtr;
        In_RAM_Data       = ram;
        In_Immediate_Data = imm;
        In_PC             = pc;
        In_Rd             = rd;
    endtask

    task automatic bubble();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic set_reads(input logic [4:0] rs, input logic [4:0] rt);
        In_Rs_Addr = rs;
        In_Rt_Addr = rt;
        #1;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst = 1'b1;
        bubble();
        In_Rs_Addr = 5'd0;
        In_Rt_Addr = 5'd0;

        // Power-on reset state.
        #12;
        set_reads(5'd5, 5'd31);
        check("por_rs_r5",    Out_Rs_Data, 32'h0);
        check("por_rt_r31",   Out_Rt_Data, 32'h0);
        check("por_count",    32'(Out_Commit_Count), 32'h0);
        check("por_valid",    32'(Out_Last_Valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Load data into r5.
        drive(1'b1, 2'b01, 32'hDEADBEEF, 32'h0000_5555, 32'h0000_0AAA, 5'd5);
        set_reads(5'd1, 5'd2);
        check("mux_ram_wb", Out_WB_Data, 32'hDEADBEEF);
        tick();
        bubble();
        set_reads(5'd5, 5'd0);
        check("ram_r5",       Out_Rs_Data, 32'hDEADBEEF);
        check("ram_r0",       Out_Rt_Data, 32'h0);
        check("ram_last_rd",  32'(Out_Last_Rd), 32'd5);
        check("ram_last_dat", Out_Last_Data, 32'hDEADBEEF);
        check("ram_valid",    32'(Out_Last_Valid), 32'd1);
        check("ram_count",    32'(Out_Commit_Count), 32'd1);

        // Immediate into r10, then PC into r31.
        drive(1'b1, 2'b00, 32'hFFFF_0000, 32'h0000_1234, 32'h0000_0AAA, 5'd10);
        set_reads(5'd10, 5'd5);
        check("mux_imm_wb", Out_WB_Data, 32'h0000_1234);
        tick();
        drive(1'b1, 2'b10, 32'hFFFF_0000, 32'h0000_7777, 32'h0040_0008, 5'd31);
        set_reads(5'd10, 5'd5);
        check("imm_r10",   Out_Rs_Data, 32'h0000_1234);
        check("keep_r5",   Out_Rt_Data, 32'hDEADBEEF);
        check("mux_pc_wb", Out_WB_Data, 32'h0040_0008);
        tick();
        bubble();
        set_reads(5'd31, 5'd10);
        check("pc_r31",       Out_Rs_Data, 32'h0040_0008);
        check("pc_last_rd",   32'(Out_Last_Rd), 32'd31);
        check("pc_count",     32'(Out_Commit_Count), 32'd3);

        // Write to r0 is dropped.
        drive(1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0);
        set_reads(5'd0, 5'd0);
        check("r0_bypass", Out_Rs_Data, 32'h0);
        tick();
        bubble();
        set_reads(5'd0, 5'd31);
        check("r0_read",    Out_Rs_Data, 32'h0);
        check("r0_count",   32'(Out_Commit_Count), 32'd3);
        check("r0_valid",   32'(Out_Last_Valid), 32'd0);
        check("r0_last_rd", 32'(Out_Last_Rd), 32'd31);

        // Write-through bypass on both ports.
        drive(1'b1, 2'b00, 32'h0, 32'h0000_0011, 32'h0, 5'd7);
        tick();
        drive(1'b1, 2'b00, 32'h0, 32'h0000_0022, 32'h0, 5'd7);
        set_reads(5'd7, 5'd7);
        check("byp_rs", Out_Rs_Data, 32'h0000_0022);
        check("byp_rt", Out_Rt_Data, 32'h0000_0022);
        tick();
        bubble();
        set_reads(5'd7, 5'd10);
        check("byp_r7",    Out_Rs_Data, 32'h0000_0022);
        check("byp_count", 32'(Out_Commit_Count), 32'd5);

        // Reserved MemtoReg code never writes.
        drive(1'b1, 2'b00, 32'h0, 32'h0000_0099, 32'h0, 5'd9);
        tick();
        drive(1'b1, 2'b11, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC, 5'd9);
        set_reads(5'd9, 5'd9);
        check("rsv_wb",     Out_WB_Data, 32'h0);
        check("rsv_nobyp",  Out_Rs_Data, 32'h0000_0099);
        tick();
        bubble();
        set_reads(5'd9, 5'd9);
        check("rsv_r9",     Out_Rs_Data, 32'h0000_0099);
        check("rsv_count",  32'(Out_Commit_Count), 32'd6);
        check("rsv_valid",  32'(Out_Last_Valid), 32'd0);

        // Asynchronous reset mid-cycle clears everything immediately.
        #2;
        rst = 1'b1;
        set_reads(5'd5, 5'd31);
        check("mrst_r5",    Out_Rs_Data, 32'h0);
        check("mrst_r31",   Out_Rt_Data, 32'h0);
        check("mrst_count", 32'(Out_Commit_Count), 32'd0);
        check("mrst_valid", 32'(Out_Last_Valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Counter wrap: 17 commits on a 4-bit counter.
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 2'b00, 32'h0, 32'h0000_0100 + 32'(i), 32'h0, 5'(i));
            tick();
            if (i == 15) check("wrap_allones", 32'(Out_Commit_Count), 32'd15);
            if (i == 16) check("wrap_zero",    32'(Out_Commit_Count), 32'd0);
        end
        bubble();
        set_reads(5'd17, 5'd3);
        check("wrap_count", 32'(Out_Commit_Count), 32'd1);
        check("wrap_r17",   Out_Rs_Data, 32'h0000_0111);
        check("wrap_r3",    Out_Rt_Data, 32'h0000_0103);

        // Reset held across a commit edge wins over the write.
        drive(1'b1, 2'b00, 32'h0, 32'h0000_0333, 32'h0, 5'd3);
        #3;
        rst = 1'b1;
        tick();
        bubble();
        @(negedge clk);
        rst = 1'b0;
        set_reads(5'd3, 5'd17);
        check("erst_r3",    Out_Rs_Data, 32'h0);
        check("erst_r17",   Out_Rt_Data, 32'h0);
        check("erst_count", 32'(Out_Commit_Count), 32'd0);
        check("erst_valid", 32'(Out_Last_Valid), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
